// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and feeds decode via a 2-entry FIFO.
// Optional misaligned-redirect trap with HALT state is built when FETCH_MISALIGN_TRAP_EN is defined.
//
// state | meaning
// WAIT  | first cycle after reset release, no fetch
// RUN   | normal fetch
// HALT  | misaligned redirect seen (FETCH_MISALIGN_TRAP_EN only); left only by reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_trap
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_RUN = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_pc_q [2];
  logic        tail;
  logic        push;
  logic        pop;
  logic        redir_en;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
`endif

  assign imem_addr = pc_q;
  assign id_valid  = (count_q != 2'd0);
  assign pop       = id_valid & id_ready;
  // With count==2 the tail slot is the head slot, freed by the same-cycle pop.
  assign tail      = head_q ^ count_q[0];
  assign redir_en  = redirect_valid & ((state_q == ST_WAIT) | (state_q == ST_RUN));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    push    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d  = trap_q;
`endif
    case (state_q)
      ST_WAIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_WAIT;
    endcase
    if (redir_en) begin
      count_d = 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        state_d = ST_HALT;
        trap_d  = 1'b1;
      end else begin
        pc_d = redirect_target;
      end
`else
      pc_d = redirect_target & 32'hFFFF_FFFC;
`endif
    end else begin
      push    = (state_q == ST_RUN) & ((count_q != 2'd2) | pop);
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) pc_d = pc_q + 32'd4;
      if (pop)  head_d = ~head_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      head_q  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instr_q[0] <= '0;
      buf_instr_q[1] <= '0;
      buf_pc_q[0]    <= '0;
      buf_pc_q[1]    <= '0;
    end else if (push) begin
      buf_instr_q[tail] <= imem_rdata;
      buf_pc_q[tail]    <= pc_q;
    end
  end

  assign id_instr    = id_valid ? buf_instr_q[head_q] : 32'd0;
  assign id_pc       = id_valid ? buf_pc_q[head_q] : 32'd0;
  assign id_pc_plus4 = id_valid ? (buf_pc_q[head_q] + 32'd4) : 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_trap  = trap_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected decode PCs are queued as stimulus is driven and
// compared when decode accepts; a second instance covers a high RESET_PC and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_hi;
  logic [31:0] imem_addr, imem_rdata, imem_addr_hi, imem_rdata_hi;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid, id_valid_hi;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic [31:0] id_instr_hi, id_pc_hi, id_pc_plus4_hi;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_trap, fetch_trap_hi;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0101_0003) ^ 32'hA53C_96E1;
  endfunction

  assign imem_rdata    = mem_word(imem_addr);
  assign imem_rdata_hi = mem_word(imem_addr_hi);

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_trap(fetch_trap)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .rst_n(rst_n_hi),
    .imem_addr(imem_addr_hi), .imem_rdata(imem_rdata_hi),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .id_ready(1'b1), .id_valid(id_valid_hi),
    .id_instr(id_instr_hi), .id_pc(id_pc_hi), .id_pc_plus4(id_pc_plus4_hi)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_trap(fetch_trap_hi)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    if (id_valid && id_ready) begin
      chk("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e);
        chk("sb_instr", id_instr, mem_word(e));
        chk("sb_pc4", id_pc_plus4, e + 32'd4);
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the next cycle.
  task automatic tick();
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    #1;
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc_plus4, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_trap", 32'(fetch_trap), 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rst_n_hi = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    id_ready = 1'b1;
    @(negedge clk);

    // Reset release, streaming with id_ready=1
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    chk("a_wait_valid", 32'(id_valid), 32'd0);
    tick();
    chk("a_run1_valid", 32'(id_valid), 32'd0);
    chk("a_run1_addr", imem_addr, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("a_stream_valid", 32'(id_valid), 32'd1);
      tick();
    end
    chk("a_sb_drained", 32'(exp_q.size()), 32'd0);

    // Stall with id_ready=0 for 5 cycles, then release
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("b_stall_valid", 32'(id_valid), 32'd1);
    chk("b_stall_pc", id_pc, 32'd0);
    chk("b_stall_addr", imem_addr, 32'd8);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      chk("b_nogap_valid", 32'(id_valid), 32'd1);
      tick();
    end
    chk("b_sb_drained", 32'(exp_q.size()), 32'd0);

    // Redirect with a full buffer and id_ready=0
    id_ready = 1'b0;
    tick();
    chk("c_full_pc", id_pc, 32'd16);
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("c_flush_valid", 32'(id_valid), 32'd0);
    chk("c_flush_addr", imem_addr, 32'h40);
    tick();
    chk("c_tgt_valid", 32'(id_valid), 32'd1);
    chk("c_tgt_pc", id_pc, 32'h40);
    chk("c_tgt_instr", id_instr, mem_word(32'h40));
    id_ready = 1'b1;
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h48);
    for (int i = 0; i < 3; i++) begin
      chk("c_stream_valid", 32'(id_valid), 32'd1);
      tick();
    end

    // Redirect coincident with a pop: popped head counts, then one bubble
    exp_q.push_back(32'h4C);
    redirect_valid = 1'b1;
    redirect_target = 32'h20;
    tick();
    redirect_valid = 1'b0;
    chk("d_bubble_valid", 32'(id_valid), 32'd0);
    chk("d_bubble_addr", imem_addr, 32'h20);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h24);
    tick();
    chk("d_after_valid", 32'(id_valid), 32'd1);
    tick();
    chk("d_after2_valid", 32'(id_valid), 32'd1);
    tick();
    chk("d_sb_drained", 32'(exp_q.size()), 32'd0);

    // Misaligned redirect target
    exp_q.push_back(32'h28);
    redirect_valid = 1'b1;
    redirect_target = 32'h12;
    tick();
    redirect_valid = 1'b0;
    chk("e_valid", 32'(id_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("e_trap", 32'(fetch_trap), 32'd1);
    chk("e_pc_held", imem_addr, 32'h2C);
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("e_halt_valid", 32'(id_valid), 32'd0);
    chk("e_halt_addr", imem_addr, 32'h2C);
    chk("e_halt_trap", 32'(fetch_trap), 32'd1);
    tick();
    chk("e_halt_valid2", 32'(id_valid), 32'd0);
`else
    chk("e_align_addr", imem_addr, 32'h10);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    tick();
    chk("e_align_pc", id_pc, 32'h10);
    tick();
    tick();
`endif
    chk("e_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted mid-stream
    id_ready = 1'b0;
    tick();
    tick();
    tick();
`ifndef FETCH_MISALIGN_TRAP_EN
    chk("f_full_before_rst", 32'(id_valid), 32'd1);
`endif
    do_reset();

    // High RESET_PC instance: PC wrap and mid-stream reset
    rst_n_hi = 1'b1;
    tick();
    tick();
    chk("h_pc0", id_pc_hi, 32'hFFFF_FFF8);
    chk("h_pc0_p4", id_pc_plus4_hi, 32'hFFFF_FFFC);
    tick();
    chk("h_pc1", id_pc_hi, 32'hFFFF_FFFC);
    chk("h_pc1_p4", id_pc_plus4_hi, 32'h0000_0000);
    tick();
    chk("h_pc2", id_pc_hi, 32'h0000_0000);
    chk("h_pc2_instr", id_instr_hi, mem_word(32'h0));
    chk("h_pc2_p4", id_pc_plus4_hi, 32'h4);
    rst_n_hi = 1'b0;
    #1;
    chk("h_rst_valid", 32'(id_valid_hi), 32'd0);
    chk("h_rst_addr", imem_addr_hi, 32'hFFFF_FFF8);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("h_rst_trap", 32'(fetch_trap_hi), 32'd0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. It owns the program counter, drives the address of the combinational instruction memory, and captures each returned word with its PC into a 2-entry fetch buffer. The buffer feeds the decode stage through a valid/ready handshake. Taken branches and jumps from execute redirect the PC and flush the buffer.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address to instruction memory; always equals the PC register.
- imem_rdata  in  32  instruction word; combinational function of imem_addr within the same cycle.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  32  new PC when redirect_valid=1.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_valid  out  1  buffer head holds a valid instruction.
- id_instr  out  32  head instruction; 0 when id_valid=0.
- id_pc  out  32  head PC; 0 when id_valid=0.
- id_pc_plus4  out  32  id_pc+4, modulo 2^32; 0 when id_valid=0.
- fetch_trap  out  1  misaligned-redirect trap; exists only with FETCH_MISALIGN_TRAP_EN.

## Operation
- State machine:
  - WAIT: first cycle after reset release; no fetch. Unconditionally → RUN.
  - RUN: normal fetch.
  - HALT: exists only with the macro.
- Signal definitions:
  - pop = id_valid & id_ready.
  - fetch = RUN & !redirect_valid & (count<2 | pop).
- On fetch:
  - Push {imem_rdata, pc} at the tail.
  - pc ← pc+4. PC wraps from 0xFFFF_FFFC to 0x0000_0000 with no flag.
- On pop: drop the head entry.
- count update: count ← count + fetch − pop. count ranges 0..2 and is never exceeded.
- When full: a push is allowed only in a cycle with a simultaneous pop.
- Redirect (in WAIT or RUN) has top priority:
  - Flush the buffer: count ← 0.
  - pc ← redirect_target.
  - No push that cycle.
  - A simultaneous pop counts as accepted by decode; the flush still discards everything.
- Without the macro, redirect_target[1:0] is forced to 0 before loading the PC.
- Buffer order is strict FIFO; there is no loss or duplication across stalls.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - pc = RESET_PC, count = 0, state = WAIT.
  - id_valid = 0; id_instr, id_pc, id_pc_plus4 = 0; fetch_trap = 0.
- Reset asserted mid-operation discards all buffered entries and any pending redirect.
- Fetch latency:
  - The word addressed in cycle N is pushed at edge N.
  - With an empty buffer, it appears on id_* with id_valid=1 in cycle N+1.
- After reset release, the first id_valid appears in the 2nd cycle of RUN, i.e. the 3rd cycle after rst_n rises.
- Redirect latency:
  - redirect_valid sampled at edge N.
  - Cycle N+1: imem_addr = target, id_valid = 0.
  - Cycle N+2: id_pc = target.
  - Redirect penalty is exactly one bubble.
- Throughput: with id_ready held at 1, one instruction per cycle.
- Outputs id_* are registered buffer contents, gated to zero when the buffer is empty. They do not depend combinationally on id_ready or redirect_valid.

## Configuration
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_target[1:0] != 0 flushes the buffer and leaves pc unchanged.
  - It sets fetch_trap=1 and enters HALT.
  - HALT performs no fetch, ignores redirects, keeps id_valid=0 and fetch_trap=1, and is exited only by reset.
- Undefined:
  - The fetch_trap port is absent and there is no HALT state.
  - Targets are silently word-aligned.

## Test plan
- Reset release, RESET_PC=0, id_ready=1, memory words W0..W4 → from the 3rd cycle, id_pc = 0,4,8,12,16 on consecutive cycles, id_instr = W0..W4, id_pc_plus4 = id_pc+4.
- Hold id_ready=0 for 5 cycles, then set it to 1 → buffer holds pc 0 and 4, imem_addr stays 8; after release id_pc sequence is 0,4,8,12 with no gap, duplicate or skip.
- With a full buffer and id_ready=0, redirect to 0x40 → next cycle id_valid=0 and imem_addr=0x40; following cycle id_pc=0x40, id_instr=mem[16].
- redirect_valid=1 and id_ready=1 in the same cycle, target 0x20 → buffer flushed, next valid id_pc=0x20, with exactly one bubble.
- RESET_PC=0xFFFF_FFF8 → id_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; id_pc_plus4 for 0xFFFF_FFFC is 0x0. Assert rst_n low mid-stream → id_valid=0 and imem_addr=RESET_PC immediately.
- Redirect to 0x12 → without the macro, the next id_pc is 0x10. With the macro, fetch_trap=1 from the next cycle, id_valid stays 0, and later redirects are ignored until reset.
